// File: rtl/hwpe_stream_tcdm_responder.sv
// hwpe_stream_tcdm_responder
//
// Memory end of the HWPE-Mem (TCDM) protocol. NB_CHAN request channels share
// one word-addressed 32-bit memory. A round-robin arbiter grants at most one
// request per cycle, combinationally in the request cycle. Every grant, read
// or write, produces a single-cycle r_valid pulse on the originating channel
// exactly LATENCY cycles later. Reads return the stored word. Writes return zero.
//
// Parameters:
//   NB_CHAN   number of request channels (>= 1)
//   MEM_WORDS memory depth in 32-bit words (power of 2)
//   LATENCY   cycles from grant edge to r_valid (>= 1)
//
// Ports (channel c occupies bit c / slice [c*W +: W] of each flat vector):
//   clk_i         clock
//   rst_i         synchronous reset, active-high
//   in_req_i      request
//   in_add_i      byte address (word index = add[$clog2(MEM_WORDS)+1:2])
//   in_wen_i      1 = read, 0 = write
//   in_be_i       byte enables for writes
//   in_data_i     write data
//   in_gnt_o      grant (combinational, one-hot or zero)
//   in_r_data_o   response data (zero when the channel has no r_valid)
//   in_r_valid_o  response valid pulse
//
// Optional feature, enabled by defining HWPE_STREAM_TCDM_RESPONDER_STALL_EN:
//   A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every
//   cycle. Grants are suppressed in cycles where its bit 0 is set.

module hwpe_stream_tcdm_responder #(
    parameter int unsigned NB_CHAN   = 2,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NB_CHAN-1:0]      in_req_i,
    input  logic [NB_CHAN*32-1:0]   in_add_i,
    input  logic [NB_CHAN-1:0]      in_wen_i,
    input  logic [NB_CHAN*4-1:0]    in_be_i,
    input  logic [NB_CHAN*32-1:0]   in_data_i,
    output logic [NB_CHAN-1:0]      in_gnt_o,
    output logic [NB_CHAN*32-1:0]   in_r_data_o,
    output logic [NB_CHAN-1:0]      in_r_valid_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

    // Per-channel views of the flat request vectors.
    logic [31:0] add_arr  [NB_CHAN];
    logic [31:0] data_arr [NB_CHAN];
    logic [3:0]  be_arr   [NB_CHAN];

    for (genvar g = 0; g < NB_CHAN; g++) begin : g_unpack
        assign add_arr[g]  = in_add_i[g*32 +: 32];
        assign data_arr[g] = in_data_i[g*32 +: 32];
        assign be_arr[g]   = in_be_i[g*4 +: 4];
    end

    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   mem_q [MEM_WORDS];

    logic          stall;

`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign stall = lfsr_q[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Round-robin arbitration: the first requester at or after the pointer wins.
    logic          gnt_any;
    logic [CW-1:0] win;
    logic [CW-1:0] cand;

    always_comb begin
        gnt_any = 1'b0;
        win     = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NB_CHAN; off++) begin
            cand = CW'((32'(rr_ptr_q) + off) % NB_CHAN);
            if (!gnt_any && in_req_i[cand]) begin
                gnt_any = 1'b1;
                win     = cand;
            end
        end
        // Reset and stall cycles issue no grant. The pointer then holds.
        if (rst_i || stall) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        in_gnt_o = '0;
        for (int unsigned c = 0; c < NB_CHAN; c++) begin
            in_gnt_o[c] = gnt_any && (win == CW'(c));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (win == CW'(NB_CHAN - 1)) ? '0 : win + CW'(1);
        end
    end

    // Selected request fields.
    logic [31:0]   sel_add;
    logic [31:0]   sel_data;
    logic [3:0]    sel_be;
    logic          sel_wen;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    assign sel_add          = add_arr[win];
    assign sel_data         = data_arr[win];
    assign sel_be           = be_arr[win];
    assign sel_wen          = in_wen_i[win];
    assign idx              = sel_add[AW+1:2];
    // Byte offset and bits above the memory range are ignored, so addresses wrap.
    assign unused_addr_bits = ^{sel_add[31:AW+2], sel_add[1:0]};
    assign rd_word          = sel_wen ? mem_q[idx] : 32'h0;

    always_ff @(posedge clk_i) begin
        if (gnt_any && !sel_wen) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_be[k]) begin
                    mem_q[idx][8*k +: 8] <= sel_data[8*k +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the grant, stage LATENCY-1 drives outputs.
    logic          vld_q   [LATENCY];
    logic          vld_d   [LATENCY];
    logic [CW-1:0] chan_q  [LATENCY];
    logic [CW-1:0] chan_d  [LATENCY];
    logic [31:0]   rdata_q [LATENCY];
    logic [31:0]   rdata_d [LATENCY];

    always_comb begin
        vld_d[0]   = gnt_any;
        chan_d[0]  = win;
        rdata_d[0] = rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            chan_d[i]  = chan_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    // Control state: reset flushes in-flight responses and the pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
            end
        end
    end

    // Payload: qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LATENCY; i++) begin
            chan_q[i]  <= chan_d[i];
            rdata_q[i] <= rdata_d[i];
        end
    end

    always_comb begin
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int unsigned c = 0; c < NB_CHAN; c++) begin
            if (vld_q[LATENCY-1] && (chan_q[LATENCY-1] == CW'(c))) begin
                in_r_valid_o[c]        = 1'b1;
                in_r_data_o[c*32 +: 32] = rdata_q[LATENCY-1];
            end
        end
    end

endmodule
